// File: rtl/dir_link_tx_if.sv
// Byte-wide valid/ready channel from the direction-link framer to the UART transmitter.
interface dir_link_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dir_link_tx.sv
// Direction-link transmitter: on each game tick, snapshots the local direction and
// eaten flag, then sends a 3-byte frame (sync, payload, inverted payload) to the UART.

// state   | meaning
// IDLE    | waiting for an enabled game tick
// SYNC    | presenting SYNC_BYTE
// PAYLOAD | presenting {2'b10, seq, eaten, dir}
// CHECK   | presenting the inverted payload; seq advances when it is accepted
module dir_link_tx #(
  parameter int         DIR_W     = 3,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             en,
  input  logic [DIR_W-1:0] dir,
  input  logic             eaten,
  dir_link_tx_if.master    tx,
  output logic             busy,
  output logic             overrun,
  output logic [1:0]       seq
);

  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CHECK} state_t;

  state_t     state, state_nxt;
  logic       s1, s2, s3;
  logic       tick, start, accept;
  logic [2:0] dir_l;
  logic       eaten_l;
  logic [7:0] payload;

  // clk_div is unrelated in phase to clk, so it is resynchronised before edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_div;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick    = s2 & ~s3;
  assign busy    = (state != IDLE);
  assign start   = tick & en & ~busy;
  assign accept  = tx.tx_valid & tx.tx_ready;
  assign payload = {2'b10, seq, eaten_l, dir_l};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_l   <= 3'd0;
      eaten_l <= 1'b0;
      seq     <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (start) begin
        dir_l   <= dir[2:0];
        eaten_l <= eaten;
      end
      // a tick during a frame is dropped, including the cycle CHECK is accepted
      if (tick & en & busy) overrun <= 1'b1;
      if ((state == CHECK) && accept) seq <= seq + 2'd1;
    end
  end

  // Outputs decode only the state register and latched payload, never tx_ready
  always_comb begin
    state_nxt   = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    case (state)
      IDLE: begin
        if (start) state_nxt = SYNC;
      end
      SYNC: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = SYNC_BYTE;
        if (accept) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = payload;
        if (accept) state_nxt = CHECK;
      end
      CHECK: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ~payload;
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dir_link_tx.sv
// Directed bench for dir_link_tx: frame content, handshake stalls, seq wrap,
// enable gating, overrun and mid-frame reset.
module tb_dir_link_tx;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;

  logic       clk, rst, clk_div, en, eaten;
  logic [2:0] dir;
  logic       busy, overrun;
  logic [1:0] seq;
  int         checks, errors;
  logic [1:0] seq_exp;

  dir_link_tx_if tx_if ();

  dir_link_tx #(.DIR_W(3), .SYNC_BYTE(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_div (clk_div),
    .en      (en),
    .dir     (dir),
    .eaten   (eaten),
    .tx      (tx_if.master),
    .busy    (busy),
    .overrun (overrun),
    .seq     (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seq_exp = 2'd0;
  endtask

  // Called on a negedge. Raises clk_div, drives tx_ready per mode
  // (0 always high, 1 random, 2 low until hold_k) and collects three bytes.
  // An optional second tick at tick2_k also changes dir/eaten. Returns on the
  // negedge after the last transfer's negedge.
  task automatic run_frame(input int mode, input int hold_k, input int tick2_k,
                           input logic [2:0] dir2,
                           output logic [7:0] b0, output logic [7:0] b1,
                           output logic [7:0] b2, output int first_k, output int last_k);
    int         n;
    logic       prev_stall;
    logic [7:0] prev_data;
    n = 0; prev_stall = 1'b0; prev_data = 8'h00;
    first_k = -1; last_k = -1; b0 = 8'h00; b1 = 8'h00; b2 = 8'h00;
    clk_div = 1'b1;
    for (int k = 0; k < 300 && n < 3; k++) begin
      if (k == 4) clk_div = 1'b0;
      if (tick2_k != 0 && k == tick2_k) begin
        clk_div = 1'b1;
        dir     = dir2;
        eaten   = ~eaten;
      end
      if (tick2_k != 0 && k == tick2_k + 4) clk_div = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_if.tx_data}, {24'd0, prev_data});
      end
      case (mode)
        0:       tx_if.tx_ready = 1'b1;
        1:       tx_if.tx_ready = 1'($urandom_range(0, 1));
        default: tx_if.tx_ready = (k >= hold_k);
      endcase
      prev_stall = tx_if.tx_valid & ~tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (n == 0) begin b0 = tx_if.tx_data; first_k = k; end
        else if (n == 1) b1 = tx_if.tx_data;
        else b2 = tx_if.tx_data;
        last_k = k;
        n++;
      end
      @(negedge clk);
    end
    chk("frame_done", n, 32'd3);
    clk_div = 1'b0;
  endtask

  task automatic frame_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] exp_b1);
    logic [7:0] nb1;
    nb1 = ~exp_b1;
    chk({tag, "_b0"}, {24'd0, b0}, 32'h0000_00A5);
    chk({tag, "_b1"}, {24'd0, b1}, {24'd0, exp_b1});
    chk({tag, "_b2"}, {24'd0, b2}, {24'd0, nb1});
  endtask

  initial begin
    logic [7:0] b0, b1, b2, exp_b1, dat;
    int         fk, lk, vcount;
    logic [2:0] dir_a;
    checks = 0; errors = 0; seq_exp = 2'd0;
    rst = 1'b1; clk_div = 1'b0; en = 1'b0; eaten = 1'b0; dir = DIR_UP;
    tx_if.tx_ready = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_if.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_seq", {30'd0, seq}, 32'd0);

    // single frame, back-to-back acceptance
    en = 1'b1; dir = DIR_UP; eaten = 1'b0;
    run_frame(0, 0, 0, 3'd0, b0, b1, b2, fk, lk);
    frame_bytes("basic", b0, b1, b2, 8'b10_00_0_000);
    chk("basic_first_k", fk, 32'd3);
    chk("basic_last_k", lk, 32'd5);
    chk("basic_busy_after", {31'd0, busy}, 32'd0);
    chk("basic_valid_after", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("basic_seq", {30'd0, seq}, 32'd1);
    seq_exp = 2'd1;

    // random backpressure
    for (int i = 0; i < 3; i++) begin
      dir = DIR_RIGHT + 3'(i); eaten = 1'(i);
      exp_b1 = {2'b10, seq_exp, eaten, dir};
      run_frame(1, 0, 0, 3'd0, b0, b1, b2, fk, lk);
      frame_bytes("rand", b0, b1, b2, exp_b1);
      seq_exp = seq_exp + 2'd1;
      vcount = 0;
      for (int c = 0; c < 8; c++) begin
        tx_if.tx_ready = 1'($urandom_range(0, 1));
        if (tx_if.tx_valid) vcount++;
        @(negedge clk);
      end
      chk("rand_no_extra", vcount, 32'd0);
    end

    // seq wrap over five frames
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dir = 3'(i); eaten = ~eaten;
      exp_b1 = {2'b10, seq_exp, eaten, dir};
      run_frame(0, 0, 0, 3'd0, b0, b1, b2, fk, lk);
      frame_bytes("wrap", b0, b1, b2, exp_b1);
      chk("wrap_seq_field", {30'd0, b1[5:4]}, {30'd0, seq_exp});
      seq_exp = seq_exp + 2'd1;
      chk("wrap_seq_out", {30'd0, seq}, {30'd0, seq_exp});
      repeat (4) @(negedge clk);
    end

    // enable gating
    en = 1'b0; clk_div = 1'b1; vcount = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) clk_div = 1'b0;
      if (tx_if.tx_valid) vcount++;
      @(negedge clk);
    end
    chk("en0_valid", vcount, 32'd0);
    chk("en0_seq", {30'd0, seq}, {30'd0, seq_exp});
    en = 1'b1; dir = DIR_LEFT; eaten = 1'b1;
    exp_b1 = {2'b10, seq_exp, 1'b1, DIR_LEFT};
    run_frame(0, 0, 0, 3'd0, b0, b1, b2, fk, lk);
    frame_bytes("left", b0, b1, b2, exp_b1);
    chk("left_eaten_bit", {31'd0, b1[3]}, 32'd1);
    seq_exp = seq_exp + 2'd1;
    repeat (4) @(negedge clk);

    // overrun: second tick during stalled SYNC
    dir_a = DIR_DOWN; dir = dir_a; eaten = 1'b0;
    exp_b1 = {2'b10, seq_exp, 1'b0, dir_a};
    chk("ovr_before", {31'd0, overrun}, 32'd0);
    run_frame(2, 20, 8, DIR_RIGHT, b0, b1, b2, fk, lk);
    frame_bytes("ovr", b0, b1, b2, exp_b1);
    chk("ovr_first_k", fk, 32'd20);
    seq_exp = seq_exp + 2'd1;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    tx_if.tx_ready = 1'b1; vcount = 0;
    for (int c = 0; c < 12; c++) begin
      if (tx_if.tx_valid) vcount++;
      @(negedge clk);
    end
    chk("ovr_one_frame", vcount, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    chk("ovr_seq", {30'd0, seq}, {30'd0, seq_exp});

    // reset while in PAYLOAD
    dir = DIR_UP; eaten = 1'b1;
    exp_b1 = {2'b10, seq_exp, 1'b1, DIR_UP};
    tx_if.tx_ready = 1'b0; clk_div = 1'b1; vcount = 0;
    for (int c = 0; c < 20 && !tx_if.tx_valid; c++) begin
      vcount++;
      @(negedge clk);
    end
    clk_div = 1'b0;
    chk("mid_sync_data", {24'd0, tx_if.tx_data}, 32'h0000_00A5);
    tx_if.tx_ready = 1'b1;
    @(negedge clk);
    tx_if.tx_ready = 1'b0;
    dat = tx_if.tx_data;
    chk("mid_payload_data", {24'd0, dat}, {24'd0, exp_b1});
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, tx_if.tx_data}, 32'd0);
    chk("mid_rst_seq", {30'd0, seq}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0; seq_exp = 2'd0;
    @(negedge clk);
    dir = DIR_RIGHT; eaten = 1'b0;
    run_frame(0, 0, 0, 3'd0, b0, b1, b2, fk, lk);
    frame_bytes("restart", b0, b1, b2, {2'b10, 2'b00, 1'b0, DIR_RIGHT});
    chk("restart_first_k", fk, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
